// File: rtl/reflet_split_mem_interface.sv
// Bridge between the Reflet core and a word-wide memory bus: 1..B-byte accesses at any
// byte address, with word-straddling accesses issued as two beats and reassembled.
module reflet_split_mem_interface #(
  parameter  int WORDSIZE = 16,
  localparam int B        = WORDSIZE / 8,
  localparam int SW       = $clog2(B) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SW-1:0]       size_used,
  input  logic [WORDSIZE-1:0] cpu_addr,
  input  logic [WORDSIZE-1:0] cpu_data_out,
  output logic [WORDSIZE-1:0] cpu_data_in,
  input  logic                cpu_write_en,
  input  logic                cpu_read_en,
  output logic                cpu_ready,
  output logic                split_access,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_data_out,
  input  logic [WORDSIZE-1:0] mem_data_in,
  output logic [B-1:0]        mem_byte_en,
  output logic                mem_write_en,
  output logic                mem_read_en,
  input  logic                mem_ready
);

  localparam int CW = SW + 1;
  localparam logic [CW-1:0]       BC       = CW'(B);
  localparam logic [SW-1:0]       SMAX     = SW'(B - 1);
  localparam logic [WORDSIZE-1:0] LOW_MASK = WORDSIZE'(B - 1);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [WORDSIZE-1:0] r_word, r_wdata, r_buf, r_data_in;
  logic [CW-1:0]       r_off, r_n;
  logic                r_write, r_split;

  logic                w_accept, w_strobe, w_beat_done, w_last_beat;
  logic [CW-1:0]       w_off_in, w_n_in, w_end;
  logic [B-1:0]        w_be0, w_be1, w_be;
  logic [WORDSIZE-1:0] w_lane_mask, w_res_mask, w_wlo, w_whi;
  logic [WORDSIZE-1:0] w_mem_masked, w_rlo, w_rhi, w_rdata;

  assign w_accept    = (r_state == S_IDLE) && enable && (cpu_write_en || cpu_read_en);
  assign w_strobe    = (r_state == S_BEAT0) || (r_state == S_BEAT1);
  assign w_beat_done = w_strobe && mem_ready;
  assign w_last_beat = w_beat_done && ((r_state == S_BEAT1) || !r_split);
  assign w_off_in    = CW'(cpu_addr & LOW_MASK);
  assign w_n_in      = (size_used > SMAX) ? BC : CW'(size_used) + CW'(1);
  assign w_end       = r_off + r_n;

  // Byte positions are counted across a two-word window: beat0 covers 0..B-1, beat1 B..2B-1.
  for (genvar gi = 0; gi < B; gi++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(gi);
    assign w_be0[gi] = (LANE >= r_off) && (LANE < w_end);
    assign w_be1[gi] = (LANE + BC) < w_end;
    assign w_lane_mask[gi*8 +: 8] = {8{w_be[gi]}};
    assign w_res_mask[gi*8 +: 8]  = {8{LANE < r_n}};
  end

  assign w_be = (r_state == S_BEAT0) ? w_be0 :
                (r_state == S_BEAT1) ? w_be1 : '0;

  assign {w_whi, w_wlo} = {WORDSIZE'(0), r_wdata} << {r_off, 3'b000};

  assign w_mem_masked = mem_data_in & w_lane_mask;
  assign w_rlo   = (r_state == S_BEAT0) ? w_mem_masked : r_buf;
  assign w_rhi   = (r_state == S_BEAT1) ? w_mem_masked : '0;
  assign w_rdata = WORDSIZE'({w_rhi, w_rlo} >> {r_off, 3'b000}) & w_res_mask;

  assign mem_addr     = (r_state == S_BEAT0) ? r_word :
                        (r_state == S_BEAT1) ? r_word + WORDSIZE'(B) : '0;
  assign mem_byte_en  = w_be;
  assign mem_data_out = (r_write ? ((r_state == S_BEAT1) ? w_whi : w_wlo) : '0) & w_lane_mask;
  assign mem_write_en = w_strobe && r_write;
  assign mem_read_en  = w_strobe && !r_write;
  assign cpu_ready    = (r_state == S_DONE);
  assign split_access = r_split && (r_state != S_IDLE);
  assign cpu_data_in  = r_data_in;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_BEAT0;
      S_BEAT0: if (mem_ready) w_state_next = r_split ? S_BEAT1 : S_DONE;
      S_BEAT1: if (mem_ready) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word    <= '0;
      r_off     <= '0;
      r_n       <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_split   <= 1'b0;
      r_buf     <= '0;
      r_data_in <= '0;
    end else begin
      if (w_accept) begin
        r_word  <= cpu_addr & ~LOW_MASK;
        r_off   <= w_off_in;
        r_n     <= w_n_in;
        r_wdata <= cpu_data_out;
        r_write <= cpu_write_en;
        r_split <= (w_off_in + w_n_in) > BC;
      end
      if (w_beat_done && !r_write && (r_state == S_BEAT0)) r_buf <= w_mem_masked;
      // Read result only changes at DONE entry and is held across later accesses.
      if (w_last_beat && !r_write) r_data_in <= w_rdata;
    end
  end

endmodule

// File: tb/tb_reflet_split_mem_interface.sv
// Self-checking bench for reflet_split_mem_interface (WORDSIZE=16): directed scenarios plus
// randomized accesses against a byte-array reference memory.
module tb_reflet_split_mem_interface;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  size_used;
  logic [15:0] cpu_addr, cpu_data_out, cpu_data_in;
  logic        cpu_write_en, cpu_read_en, cpu_ready, split_access;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic [1:0]  mem_byte_en;
  logic        mem_write_en, mem_read_en, mem_ready;

  int checks = 0;
  int passes = 0;

  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] dout;
    logic        wr;
    logic        rd;
    logic        rdy;
  } cyc_t;
  cyc_t rec[$];

  reflet_split_mem_interface #(.WORDSIZE(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .size_used(size_used),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en), .cpu_ready(cpu_ready),
    .split_access(split_access), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_byte_en(mem_byte_en), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_data_in = {mem[mem_addr + 16'd1], mem[mem_addr]};

  function automatic int nbytes(input logic [1:0] s);
    return (s > 2'd1) ? 2 : int'(s) + 1;
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic [1:0] s);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < nbytes(s); k++) r[8*k +: 8] = ref_mem[a + 16'(k)];
    return r;
  endfunction

  function automatic void ref_write(input logic [15:0] a, input logic [1:0] s, input logic [15:0] d);
    for (int k = 0; k < nbytes(s); k++) ref_mem[a + 16'(k)] = d[8*k +: 8];
  endfunction

  // Lane L of beat b holds byte position L+2b of the window starting at the aligned word.
  function automatic logic [1:0] exp_be(input logic [15:0] a, input logic [1:0] s, input int beat);
    logic [1:0] be;
    int pos;
    for (int l = 0; l < 2; l++) begin
      pos = l + 2 * beat;
      be[l] = (pos >= int'(a[0])) && (pos < int'(a[0]) + nbytes(s));
    end
    return be;
  endfunction

  function automatic logic [15:0] exp_dout(input logic [15:0] a, input logic [1:0] s,
                                           input logic [15:0] d, input int beat);
    logic [15:0] r;
    logic [1:0]  be;
    int pos;
    r  = '0;
    be = exp_be(a, s, beat);
    for (int l = 0; l < 2; l++) begin
      pos = l + 2 * beat;
      if (be[l]) r[8*l +: 8] = d[8*(pos - int'(a[0])) +: 8];
    end
    return r;
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // mode 0: mem_ready high; 1: random stalls; 2: stall_n cycles on beat number stall_beat.
  task automatic access(input bit wr, input bit rd, input logic [15:0] addr, input logic [1:0] size,
                        input logic [15:0] wdata, input int mode, input int stall_beat,
                        input int stall_n, output logic [15:0] rdata, output int cycles,
                        output bit split, output bit ok);
    int beats;
    int left;
    rec.delete();
    ok = 0; beats = 0; left = stall_n; cycles = 0; rdata = '0; split = 0;
    @(negedge clk);
    cpu_addr = addr; cpu_data_out = wdata; size_used = size;
    cpu_write_en = wr; cpu_read_en = rd; mem_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cpu_addr = 16'($urandom); cpu_data_out = 16'($urandom); size_used = 2'($urandom);
        enable = 1'($urandom_range(0, 1));
      end
      if (cpu_ready) begin
        rdata = cpu_data_in; split = split_access; cycles = c + 2; ok = 1;
        break;
      end
      if (mode == 1) mem_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && beats == stall_beat && left > 0 && (mem_read_en || mem_write_en)) begin
        mem_ready = 1'b0;
        left--;
      end else mem_ready = 1'b1;
      #1;
      if (mem_read_en || mem_write_en) begin
        rec.push_back('{addr: mem_addr, be: mem_byte_en, dout: mem_data_out,
                        wr: mem_write_en, rd: mem_read_en, rdy: mem_ready});
        if (mem_write_en && mem_ready) begin
          if (mem_byte_en[0]) mem[mem_addr] = mem_data_out[7:0];
          if (mem_byte_en[1]) mem[mem_addr + 16'd1] = mem_data_out[15:8];
        end
        if (mem_ready) beats++;
      end
    end
    cpu_write_en = 1'b0; cpu_read_en = 1'b0; mem_ready = 1'b1; enable = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({cpu_data_in, cpu_ready, split_access, mem_addr, mem_data_out, mem_byte_en,
         mem_write_en, mem_read_en} !== '0)
      $display("FAIL reset_outputs got data_in=%h ready=%b split=%b addr=%h dout=%h be=%b we=%b re=%b want all 0",
               cpu_data_in, cpu_ready, split_access, mem_addr, mem_data_out, mem_byte_en,
               mem_write_en, mem_read_en);
    else passes++;
  endtask

  task automatic test_aligned_read();
    logic [15:0] r; int cyc; bit sp, ok;
    poke(16'h0010, 8'hEF); poke(16'h0011, 8'hBE);
    access(0, 1, 16'h0010, 2'd1, 16'h0, 0, 0, 0, r, cyc, sp, ok);
    checks++;
    if (!ok || cyc != 3) $display("FAIL aligned_latency got ok=%0b cycles=%0d want 3", ok, cyc);
    else passes++;
    checks++;
    if (!(rec.size() == 1 && rec[0].addr == 16'h0010 && rec[0].be == 2'b11 && rec[0].rd))
      $display("FAIL aligned_beat got n=%0d addr=%h be=%b want 1 beat 0010 be 11",
               rec.size(), rec[0].addr, rec[0].be);
    else passes++;
    checks++;
    if (r !== 16'hBEEF || sp !== 1'b0) $display("FAIL aligned_data got %h split=%b want beef split=0", r, sp);
    else passes++;
  endtask

  task automatic test_split_read();
    logic [15:0] r; int cyc; bit sp, ok;
    poke(16'h0010, 8'hAA); poke(16'h0011, 8'h34); poke(16'h0012, 8'h12); poke(16'h0013, 8'hBB);
    access(0, 1, 16'h0011, 2'd1, 16'h0, 0, 0, 0, r, cyc, sp, ok);
    checks++;
    if (!(rec.size() == 2 && rec[0].addr == 16'h0010 && rec[0].be == 2'b10 &&
          rec[1].addr == 16'h0012 && rec[1].be == 2'b01))
      $display("FAIL split_read_beats got n=%0d a0=%h be0=%b a1=%h be1=%b want 0010/10 0012/01",
               rec.size(), rec[0].addr, rec[0].be, rec[1].addr, rec[1].be);
    else passes++;
    checks++;
    if (r !== 16'h1234 || sp !== 1'b1 || cyc != 4)
      $display("FAIL split_read_data got %h split=%b cycles=%0d want 1234 split=1 cycles=4", r, sp, cyc);
    else passes++;
  endtask

  task automatic test_split_write();
    logic [15:0] r; int cyc; bit sp, ok;
    access(1, 0, 16'h0011, 2'd1, 16'hA55A, 0, 0, 0, r, cyc, sp, ok);
    ref_write(16'h0011, 2'd1, 16'hA55A);
    checks++;
    if (!(ok && rec.size() == 2 && rec[0].wr && rec[0].addr == 16'h0010 && rec[0].be == 2'b10 &&
          rec[0].dout == 16'h5A00 && rec[1].addr == 16'h0012 && rec[1].be == 2'b01 &&
          rec[1].dout == 16'h00A5))
      $display("FAIL split_write_beats got n=%0d d0=%h be0=%b d1=%h be1=%b want 5a00/10 00a5/01",
               rec.size(), rec[0].dout, rec[0].be, rec[1].dout, rec[1].be);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [15:0] r; int cyc; bit sp, ok;
    poke(16'hFFFF, 8'hC3); poke(16'h0000, 8'h3C);
    access(0, 1, 16'hFFFF, 2'd1, 16'h0, 0, 0, 0, r, cyc, sp, ok);
    checks++;
    if (!(rec.size() == 2 && rec[0].addr == 16'hFFFE && rec[0].be == 2'b10 &&
          rec[1].addr == 16'h0000 && rec[1].be == 2'b01 && r == 16'h3CC3))
      $display("FAIL wrap_read got n=%0d a0=%h a1=%h data=%h want fffe 0000 3cc3",
               rec.size(), rec[0].addr, rec[1].addr, r);
    else passes++;
    poke(16'h0012, 8'h00); poke(16'h0013, 8'h77);
    access(0, 1, 16'h0013, 2'd0, 16'h0, 0, 0, 0, r, cyc, sp, ok);
    checks++;
    if (!(ok && rec.size() == 1 && rec[0].be == 2'b10 && r == 16'h0077 && !sp))
      $display("FAIL byte_read got n=%0d be=%b data=%h split=%b want 1 beat be 10 0077 split 0",
               rec.size(), rec[0].be, r, sp);
    else passes++;
  endtask

  task automatic test_stall();
    logic [15:0] r; int cyc; bit sp, ok, stable;
    access(0, 1, 16'h0011, 2'd1, 16'h0, 2, 1, 3, r, cyc, sp, ok);
    stable = (rec.size() == 5) && !rec[1].rdy && !rec[2].rdy && !rec[3].rdy && rec[4].rdy;
    for (int j = 2; j < rec.size(); j++)
      if (rec[j].addr != rec[1].addr || rec[j].be != rec[1].be || !rec[j].rd) stable = 0;
    checks++;
    if (!stable || rec[1].addr != 16'h0012)
      $display("FAIL stall_stability got n=%0d addr=%h be=%b want 5 cycles addr 0012 held", rec.size(),
               rec[1].addr, rec[1].be);
    else passes++;
    checks++;
    if (!ok || cyc != 7 || r !== ref_read(16'h0011, 2'd1))
      $display("FAIL stall_latency got cycles=%0d data=%h want 7 %h", cyc, r, ref_read(16'h0011, 2'd1));
    else passes++;
  endtask

  task automatic test_write_wins();
    logic [15:0] r; int cyc; bit sp, ok;
    access(1, 1, 16'h0041, 2'd0, 16'h00D2, 0, 0, 0, r, cyc, sp, ok);
    ref_write(16'h0041, 2'd0, 16'h00D2);
    checks++;
    if (!(ok && rec.size() == 1 && rec[0].wr && !rec[0].rd && rec[0].dout == 16'hD200))
      $display("FAIL write_wins got n=%0d we=%b re=%b dout=%h want write d200",
               rec.size(), rec[0].wr, rec[0].rd, rec[0].dout);
    else passes++;
  endtask

  task automatic test_enable();
    logic [15:0] r; int cyc; bit sp, ok, bad;
    @(negedge clk);
    enable = 1'b0; cpu_read_en = 1'b1; cpu_addr = 16'h0020; size_used = 2'd1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_read_en || mem_write_en || cpu_ready) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL enable_block got bus activity with enable=0 want none");
    else passes++;
    cpu_read_en = 1'b0; enable = 1'b1;
    access(0, 1, 16'h0020, 2'd1, 16'h0, 0, 0, 0, r, cyc, sp, ok);
    checks++;
    if (!ok || r !== ref_read(16'h0020, 2'd1))
      $display("FAIL enable_resume got ok=%0b data=%h want %h", ok, r, ref_read(16'h0020, 2'd1));
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; int cyc; bit sp, ok, bad;
    @(negedge clk);
    enable = 1'b1; cpu_addr = 16'h0011; size_used = 2'd1; cpu_read_en = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!(mem_read_en && mem_addr == 16'h0012 && split_access))
      $display("FAIL reset_mid_beat1 got re=%b addr=%h split=%b want 1 0012 1", mem_read_en, mem_addr,
               split_access);
    else passes++;
    reset = 1'b0; cpu_read_en = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({cpu_data_in, cpu_ready, split_access, mem_addr, mem_byte_en, mem_write_en, mem_read_en} !== '0)
      $display("FAIL reset_mid_outputs got data_in=%h ready=%b split=%b addr=%h be=%b re=%b want all 0",
               cpu_data_in, cpu_ready, split_access, mem_addr, mem_byte_en, mem_read_en);
    else passes++;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ready || mem_read_en || mem_write_en) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL reset_mid_quiet got activity after reset want none");
    else passes++;
    access(0, 1, 16'h0010, 2'd1, 16'h0, 0, 0, 0, r, cyc, sp, ok);
    checks++;
    if (!ok || cyc != 3 || r !== ref_read(16'h0010, 2'd1))
      $display("FAIL reset_mid_fresh got cycles=%0d data=%h want 3 %h", cyc, r, ref_read(16'h0010, 2'd1));
    else passes++;
  endtask

  task automatic test_random();
    logic [15:0] a, d, r, er; logic [1:0] s; bit wr, sp, ok, bad, esplit; int cyc, nb, stalls;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom_range(0, 63));
      s  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      esplit = (int'(a[0]) + nbytes(s)) > 2;
      er = ref_read(a, s);
      if (wr) ref_write(a, s, d);
      access(wr, !wr, a, s, d, 1, 0, 0, r, cyc, sp, ok);
      bad = 0; nb = 0; stalls = 0;
      for (int j = 0; j < rec.size(); j++) begin
        if (j > 0 && !rec[j-1].rdy &&
            {rec[j].addr, rec[j].be, rec[j].dout, rec[j].wr, rec[j].rd} !=
            {rec[j-1].addr, rec[j-1].be, rec[j-1].dout, rec[j-1].wr, rec[j-1].rd}) bad = 1;
        if (rec[j].addr != (a & 16'hFFFE) + 16'(2 * nb) || rec[j].be != exp_be(a, s, nb) ||
            rec[j].wr != wr || rec[j].rd != !wr ||
            rec[j].dout != (wr ? exp_dout(a, s, d, nb) : 16'h0)) bad = 1;
        if (rec[j].rdy) nb++;
        else stalls++;
      end
      if (nb != (esplit ? 2 : 1)) bad = 1;
      $display("txn %0d %s addr=%h size=%0d wdata=%h rdata=%h stalls=%0d", i, wr ? "wr" : "rd", a, s, d, r,
               stalls);
      checks++;
      if (!ok || cyc != (esplit ? 4 : 3) + stalls)
        $display("FAIL rand_latency txn %0d got cycles=%0d want %0d", i, cyc, (esplit ? 4 : 3) + stalls);
      else passes++;
      checks++;
      if (bad) $display("FAIL rand_beats txn %0d got %0d bus beats with wrong addr/be/data want %0d", i, nb,
                        esplit ? 2 : 1);
      else passes++;
      checks++;
      if (sp !== esplit) $display("FAIL rand_split txn %0d got %b want %b", i, sp, esplit);
      else passes++;
      if (!wr) begin
        checks++;
        if (r !== er) $display("FAIL rand_read txn %0d got %h want %h", i, r, er);
        else passes++;
      end
    end
  endtask

  task automatic test_memory_image();
    int diff;
    diff = 0;
    for (int k = 0; k < 65536; k++) if (mem[k] !== ref_mem[k]) diff++;
    checks++;
    if (diff != 0) $display("FAIL memory_image got %0d differing bytes want 0", diff);
    else passes++;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; size_used = '0; cpu_addr = '0; cpu_data_out = '0;
    cpu_write_en = 1'b0; cpu_read_en = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      mem[k] = 8'($urandom);
      ref_mem[k] = mem[k];
    end
    repeat (3) @(posedge clk);
    test_reset();
    reset = 1'b1;
    test_aligned_read();
    test_split_read();
    test_split_write();
    test_wrap();
    test_stall();
    test_write_wins();
    test_enable();
    test_reset_mid();
    test_random();
    test_memory_image();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
